// File: rtl/pattern_ctrl_pkg.sv
// Shared types and constants for the pattern mode controller: FSM states,
// keystroke codes, pattern codes and small sizing/stepping helpers.
package pattern_ctrl_pkg;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      PEND   = 2'd1,
      AUTO   = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_0 = 8'h30;
   localparam logic [7:0] ASCII_9 = 8'h39;
   localparam logic [7:0] ASCII_A = 8'h41;
   localparam logic [7:0] ASCII_a = 8'h61;

   localparam logic [3:0] PAT_BLACK = 4'd0;
   localparam logic [3:0] PAT_RED   = 4'd1;
   localparam logic [3:0] PAT_GREEN = 4'd2;
   localparam logic [3:0] PAT_BLUE  = 4'd3;

   // Width that can hold n-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [3:0] next_pattern(input logic [3:0] cur,
                                               input int unsigned num);
      if (32'(cur) >= num - 1)
         return PAT_BLACK;
      else
         return cur + 4'd1;
   endfunction

endpackage

// File: rtl/pattern_mode_controller_frame_step_counter.sv
// Frame-start edge detector plus dwell counter; o_Step fires on the tick that
// completes FRAMES_PER_STEP enabled ticks.
module frame_step_counter
   import pattern_ctrl_pkg::*;
#(
   parameter int unsigned FRAMES_PER_STEP = 60
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_Frame_Start,
   input  logic i_Clear,
   input  logic i_Enable,
   output logic o_Tick,
   output logic o_Step
);

   localparam int unsigned CW = cnt_width(FRAMES_PER_STEP);
   localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

   logic          r_Prev;
   logic [CW-1:0] r_Cnt;
   logic          w_Last;

   assign o_Tick = i_Frame_Start & ~r_Prev;
   assign w_Last = (r_Cnt == LAST);
   assign o_Step = o_Tick & i_Enable & w_Last;

   // Clear beats counting so a byte arriving with a tick never advances the dwell.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_Prev <= 1'b0;
         r_Cnt  <= '0;
      end else begin
         r_Prev <= i_Frame_Start;
         if (i_Clear)
            r_Cnt <= '0;
         else if (o_Tick && i_Enable)
            r_Cnt <= w_Last ? '0 : r_Cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pattern_mode_controller.sv
// Decodes UART keystrokes into pattern selections and applies them only at
// frame boundaries; also supports an auto-cycle mode driven by frame count.
module pattern_mode_controller
   import pattern_ctrl_pkg::*;
#(
   parameter int unsigned FRAMES_PER_STEP = 60,
   parameter int unsigned NUM_PATTERNS    = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   input  logic       i_Frame_Start,
   output logic [3:0] o_Pattern,
   output logic       o_Update,
   output logic       o_Auto,
   output logic       o_Pending
);

   state_t     r_State;
   state_t     w_State_Nxt;
   logic [3:0] r_Pattern;
   logic [3:0] r_Next;
   logic       r_Update;
   logic       r_Auto;
   logic       r_Pending;

   logic [3:0] w_Pattern_Nxt;
   logic [3:0] w_Next_Nxt;
   logic       w_Update_Nxt;

   logic       w_In_Digit_Range;
   logic [3:0] w_Digit;
   logic       w_Digit_Ok;
   logic       w_Toggle;
   logic       w_Byte_Evt;
   logic       w_Tick;
   logic       w_Step;

   // ASCII digits carry their value in the low nibble.
   assign w_In_Digit_Range = (i_RX_Byte >= ASCII_0) && (i_RX_Byte <= ASCII_9);
   assign w_Digit          = i_RX_Byte[3:0];
   assign w_Digit_Ok       = i_RX_DV && w_In_Digit_Range && (32'(w_Digit) < NUM_PATTERNS);
   assign w_Toggle         = i_RX_DV && ((i_RX_Byte == ASCII_A) || (i_RX_Byte == ASCII_a));
   assign w_Byte_Evt       = w_Digit_Ok | w_Toggle;

   frame_step_counter #(
      .FRAMES_PER_STEP (FRAMES_PER_STEP)
   ) u_step (
      .CLK           (CLK),
      .RST           (RST),
      .i_Frame_Start (i_Frame_Start),
      .i_Clear       (w_Byte_Evt),
      .i_Enable      ((r_State == AUTO) && !w_Byte_Evt),
      .o_Tick        (w_Tick),
      .o_Step        (w_Step)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_State   <= MANUAL;
         r_Pattern <= PAT_BLACK;
         r_Next    <= PAT_BLACK;
         r_Update  <= 1'b0;
         r_Auto    <= 1'b0;
         r_Pending <= 1'b0;
      end else begin
         r_State   <= w_State_Nxt;
         r_Pattern <= w_Pattern_Nxt;
         r_Next    <= w_Next_Nxt;
         r_Update  <= w_Update_Nxt;
         r_Auto    <= (w_State_Nxt == AUTO);
         r_Pending <= (w_State_Nxt == PEND);
      end
   end

   always_comb begin
      w_State_Nxt = r_State;
      case (r_State)
         MANUAL: begin
            if (w_Digit_Ok)    w_State_Nxt = PEND;
            else if (w_Toggle) w_State_Nxt = AUTO;
         end
         PEND: begin
            if (w_Toggle)    w_State_Nxt = AUTO;
            else if (w_Tick) w_State_Nxt = MANUAL;
         end
         AUTO: begin
            if (w_Digit_Ok)    w_State_Nxt = PEND;
            else if (w_Toggle) w_State_Nxt = MANUAL;
         end
         default: w_State_Nxt = MANUAL;
      endcase
   end

   // In PEND a same-cycle digit is applied directly at the tick (last byte wins).
   always_comb begin
      w_Pattern_Nxt = r_Pattern;
      w_Next_Nxt    = r_Next;
      w_Update_Nxt  = 1'b0;
      case (r_State)
         MANUAL: begin
            if (w_Digit_Ok) w_Next_Nxt = w_Digit;
         end
         PEND: begin
            if (!w_Toggle) begin
               if (w_Digit_Ok) w_Next_Nxt = w_Digit;
               if (w_Tick) begin
                  w_Pattern_Nxt = w_Digit_Ok ? w_Digit : r_Next;
                  w_Update_Nxt  = 1'b1;
               end
            end
         end
         AUTO: begin
            if (w_Digit_Ok) begin
               w_Next_Nxt = w_Digit;
            end else if (!w_Toggle && w_Step) begin
               w_Pattern_Nxt = next_pattern(r_Pattern, NUM_PATTERNS);
               w_Update_Nxt  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign o_Pattern = r_Pattern;
   assign o_Update  = r_Update;
   assign o_Auto    = r_Auto;
   assign o_Pending = r_Pending;

endmodule
